// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and address-field helpers for the parametrised
// direct-mapped write-back cache controller.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, COMP, EVICT, FILL, RETRY} state_e;

    function automatic int off_w(input int words);
        return $clog2(words) + 1;
    endfunction

    function automatic int tag_w(input int addr_w, input int index_w, input int words);
        return addr_w - index_w - off_w(words);
    endfunction

    // Returns a width-bit field starting at lsb; callers narrow the result.
    function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb,
                                               input int width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_ctrl_fsm_p_if.sv
// CPU, cache-array and memory signals of the cache controller; master is the
// controller side, slave is the environment (CPU + cache + memory) side.
interface cache_ctrl_fsm_p_if
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 4,
    parameter int INDEX_W = 8
) ();
    localparam int OFF_W = off_w(WORDS);
    localparam int TAG_W = tag_w(ADDR_W, INDEX_W, WORDS);

    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_data;
    logic               req_rd;
    logic               req_wr;
    logic [TAG_W-1:0]   c_tag_out;
    logic [DATA_W-1:0]  c_data_out;
    logic               c_hit;
    logic               c_valid;
    logic               c_dirty;
    logic               c_err;
    logic [DATA_W-1:0]  m_data_out;
    logic               m_stall;
    logic [WORDS-1:0]   m_busy;
    logic               m_err;
    logic               fc_enable;
    logic               fc_comp;
    logic               fc_write;
    logic               fc_valid_in;
    logic [TAG_W-1:0]   fc_tag_in;
    logic [INDEX_W-1:0] fc_index;
    logic [OFF_W-1:0]   fc_offset;
    logic [DATA_W-1:0]  fc_data_in;
    logic [ADDR_W-1:0]  fm_addr;
    logic [DATA_W-1:0]  fm_data_in;
    logic               fm_wr;
    logic               fm_rd;
    logic [DATA_W-1:0]  fs_data_out;
    logic               fs_done;
    logic               fs_stall;
    logic               fs_cachehit;
    logic               fs_err;

    modport master (
        input  req_addr, req_data, req_rd, req_wr,
        input  c_tag_out, c_data_out, c_hit, c_valid, c_dirty, c_err,
        input  m_data_out, m_stall, m_busy, m_err,
        output fc_enable, fc_comp, fc_write, fc_valid_in, fc_tag_in, fc_index, fc_offset,
        output fc_data_in, fm_addr, fm_data_in, fm_wr, fm_rd,
        output fs_data_out, fs_done, fs_stall, fs_cachehit, fs_err
    );

    modport slave (
        output req_addr, req_data, req_rd, req_wr,
        output c_tag_out, c_data_out, c_hit, c_valid, c_dirty, c_err,
        output m_data_out, m_stall, m_busy, m_err,
        input  fc_enable, fc_comp, fc_write, fc_valid_in, fc_tag_in, fc_index, fc_offset,
        input  fc_data_in, fm_addr, fm_data_in, fm_wr, fm_rd,
        input  fs_data_out, fs_done, fs_stall, fs_cachehit, fs_err
    );

endinterface

// File: rtl/cache_xfer_seq.sv
// Line-transfer sequencer: per-word issue counter gated by stall/bank busy,
// a MEM_LAT-deep in-flight shift register and a return counter.
module cache_xfer_seq #(
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     issue_en_i,
    input  logic                     track_i,
    input  logic                     stall_i,
    input  logic [WORDS-1:0]         busy_i,
    output logic [$clog2(WORDS)-1:0] issue_idx_o,
    output logic                     issue_req_o,
    output logic                     last_issue_o,
    output logic [$clog2(WORDS)-1:0] ret_idx_o,
    output logic                     ret_valid_o,
    output logic                     last_ret_o
);
    localparam int IW = $clog2(WORDS);

    logic [IW:0]        issue_cnt_q, issue_cnt_d;
    logic [IW-1:0]      ret_cnt_q, ret_cnt_d;
    logic [MEM_LAT-1:0] flight_q, flight_d;
    logic               issue_acc;

    // The extra counter bit marks "all words issued" so issuing stops cleanly.
    assign issue_idx_o  = issue_cnt_q[IW-1:0];
    assign issue_req_o  = issue_en_i && (issue_cnt_q != (IW+1)'(WORDS));
    assign issue_acc    = issue_req_o && !stall_i && !busy_i[issue_idx_o];
    assign last_issue_o = issue_acc && (issue_idx_o == IW'(WORDS - 1));
    assign ret_idx_o    = ret_cnt_q;
    assign ret_valid_o  = flight_q[MEM_LAT-1];
    assign last_ret_o   = ret_valid_o && (ret_cnt_q == IW'(WORDS - 1));

    assign flight_d[0] = issue_acc && track_i;
    for (genvar gi = 1; gi < MEM_LAT; gi++) begin : g_flight
        assign flight_d[gi] = flight_q[gi-1];
    end

    always_comb begin
        issue_cnt_d = issue_cnt_q + (IW+1)'(issue_acc);
        ret_cnt_d   = ret_cnt_q + IW'(ret_valid_o);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            flight_q    <= '0;
        end else if (clr_i) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            flight_q    <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            flight_q    <= flight_d;
        end
    end

endmodule

// File: rtl/cache_ctrl_fsm_p.sv
// Direct-mapped write-back / write-allocate cache controller: latches the
// request, compares, evicts a dirty line, refills it, then re-compares.
module cache_ctrl_fsm_p
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 4,
    parameter int INDEX_W = 8,
    parameter int MEM_LAT = 2
) (
    input logic                clk,
    input logic                rst,
    cache_ctrl_fsm_p_if.master bus
);
    localparam int OFF_W = off_w(WORDS);
    localparam int TAG_W = tag_w(ADDR_W, INDEX_W, WORDS);
    localparam int IW    = $clog2(WORDS);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, cur_addr;
    logic [DATA_W-1:0]  data_q, data_d, result_q, result_d, cur_data;
    logic               op_wr_q, op_wr_d, err_q, err_d, cur_wr;
    logic [TAG_W-1:0]   cur_tag;
    logic [INDEX_W-1:0] cur_idx;
    logic [OFF_W-1:0]   cur_off;
    logic               seq_clr, seq_issue_en, seq_track, cmp_drive, hit;
    logic [IW-1:0]      issue_idx, ret_idx;
    logic               issue_req, last_issue, ret_valid, last_ret;

    // In IDLE the compare is driven straight from the CPU inputs, afterwards from the latch.
    assign cur_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
    assign cur_data = (state_q == IDLE) ? bus.req_data : data_q;
    assign cur_wr   = (state_q == IDLE) ? bus.req_wr : op_wr_q;
    assign cur_off  = OFF_W'(addr_field(32'(cur_addr), 0, OFF_W));
    assign cur_idx  = INDEX_W'(addr_field(32'(cur_addr), OFF_W, INDEX_W));
    assign cur_tag  = TAG_W'(addr_field(32'(cur_addr), OFF_W + INDEX_W, TAG_W));
    assign hit      = bus.c_hit && bus.c_valid;

    cache_xfer_seq #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) u_seq (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (seq_clr),
        .issue_en_i   (seq_issue_en),
        .track_i      (seq_track),
        .stall_i      (bus.m_stall),
        .busy_i       (bus.m_busy),
        .issue_idx_o  (issue_idx),
        .issue_req_o  (issue_req),
        .last_issue_o (last_issue),
        .ret_idx_o    (ret_idx),
        .ret_valid_o  (ret_valid),
        .last_ret_o   (last_ret)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            op_wr_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            op_wr_q  <= op_wr_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        data_d          = data_q;
        op_wr_d         = op_wr_q;
        err_d           = err_q;
        result_d        = result_q;
        seq_clr         = 1'b0;
        seq_issue_en    = 1'b0;
        seq_track       = 1'b0;
        cmp_drive       = 1'b0;
        bus.fc_enable   = 1'b0;
        bus.fc_comp     = 1'b0;
        bus.fc_write    = 1'b0;
        bus.fc_valid_in = 1'b1;
        bus.fc_tag_in   = '0;
        bus.fc_index    = '0;
        bus.fc_offset   = '0;
        bus.fc_data_in  = '0;
        bus.fm_addr     = '0;
        bus.fm_data_in  = '0;
        bus.fm_wr       = 1'b0;
        bus.fm_rd       = 1'b0;
        bus.fs_data_out = '0;
        bus.fs_done     = 1'b0;
        bus.fs_stall    = 1'b0;
        bus.fs_cachehit = 1'b0;
        bus.fs_err      = 1'b0;
        // Gating on rst keeps outputs at default while reset is held, even with requests present.
        if (rst) begin
            if (state_q != IDLE) begin
                bus.fs_stall = 1'b1;
                err_d        = err_q | bus.c_err | bus.m_err;
            end
            case (state_q)
                IDLE: begin
                    err_d   = 1'b0;
                    seq_clr = 1'b1;
                    if (bus.req_rd ^ bus.req_wr) begin
                        addr_d       = bus.req_addr;
                        data_d       = bus.req_data;
                        op_wr_d      = bus.req_wr;
                        cmp_drive    = 1'b1;
                        bus.fs_stall = 1'b1;
                        state_d      = COMP;
                    end else if (bus.req_rd && bus.req_wr) begin
                        bus.fs_err = 1'b1;
                    end
                end
                COMP: begin
                    seq_clr   = 1'b1;
                    cmp_drive = 1'b1;
                    if (hit) begin
                        bus.fs_done     = 1'b1;
                        bus.fs_cachehit = 1'b1;
                        bus.fs_err      = err_d;
                        bus.fs_data_out = op_wr_q ? data_q : bus.c_data_out;
                        state_d         = IDLE;
                    end else if (bus.c_valid && bus.c_dirty) begin
                        state_d = EVICT;
                    end else begin
                        state_d = FILL;
                    end
                end
                EVICT: begin
                    seq_issue_en   = 1'b1;
                    bus.fc_enable  = 1'b1;
                    bus.fc_index   = cur_idx;
                    bus.fc_offset  = {issue_idx, 1'b0};
                    bus.fm_wr      = issue_req;
                    bus.fm_addr    = {bus.c_tag_out, cur_idx, issue_idx, 1'b0};
                    bus.fm_data_in = bus.c_data_out;
                    if (last_issue) begin
                        seq_clr = 1'b1;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    seq_issue_en = 1'b1;
                    seq_track    = 1'b1;
                    bus.fm_rd    = issue_req;
                    bus.fm_addr  = {cur_tag, cur_idx, issue_idx, 1'b0};
                    if (ret_valid) begin
                        bus.fc_enable  = 1'b1;
                        bus.fc_write   = 1'b1;
                        bus.fc_tag_in  = cur_tag;
                        bus.fc_index   = cur_idx;
                        bus.fc_offset  = {ret_idx, 1'b0};
                        bus.fc_data_in = bus.m_data_out;
                        if (ret_idx == cur_off[OFF_W-1:1]) begin
                            result_d = bus.m_data_out;
                        end
                    end
                    if (last_ret) begin
                        state_d = RETRY;
                    end
                end
                RETRY: begin
                    cmp_drive       = 1'b1;
                    bus.fs_done     = 1'b1;
                    bus.fs_err      = err_d | !hit;
                    bus.fs_data_out = op_wr_q ? data_q : result_q;
                    state_d         = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (cmp_drive) begin
                bus.fc_enable  = 1'b1;
                bus.fc_comp    = 1'b1;
                bus.fc_write   = cur_wr;
                bus.fc_tag_in  = cur_tag;
                bus.fc_index   = cur_idx;
                bus.fc_offset  = cur_off;
                bus.fc_data_in = cur_data;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm_p.sv
// Directed bench for cache_ctrl_fsm_p (WORDS=4, MEM_LAT=2): hits, clean and
// dirty misses, bank-busy fill, protocol and memory errors, mid-fill reset.
module tb_cache_ctrl_fsm_p;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cache_ctrl_fsm_p_if bus ();

    cache_ctrl_fsm_p dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_rd     = 1'b0;
        bus.req_wr     = 1'b0;
        bus.c_tag_out  = '0;
        bus.c_data_out = '0;
        bus.c_hit      = 1'b0;
        bus.c_valid    = 1'b0;
        bus.c_dirty    = 1'b0;
        bus.c_err      = 1'b0;
        bus.m_data_out = '0;
        bus.m_stall    = 1'b0;
        bus.m_busy     = '0;
        bus.m_err      = 1'b0;
    endtask

    task automatic hit_txn(input string nm, input logic [15:0] addr, input logic wr,
                           input logic [15:0] wdata, input logic [4:0] e_tag,
                           input logic [7:0] e_idx, input logic [2:0] e_off);
        @(negedge clk);
        idle_inputs();
        bus.req_addr = addr;
        bus.req_rd   = !wr;
        bus.req_wr   = wr;
        bus.req_data = wdata;
        #1;
        chk({nm, ":accept"}, {bus.fc_enable, bus.fc_comp, bus.fc_write, bus.fs_stall, bus.fs_done},
            {1'b1, 1'b1, wr, 1'b1, 1'b0});
        chk({nm, ":fields"}, {bus.fc_tag_in, bus.fc_index, bus.fc_offset}, {e_tag, e_idx, e_off});
        @(negedge clk);
        idle_inputs();
        bus.c_hit      = 1'b1;
        bus.c_valid    = 1'b1;
        bus.c_data_out = 16'hBEEF;
        #1;
        chk({nm, ":done"}, {bus.fs_done, bus.fs_cachehit, bus.fs_err, bus.fs_stall}, 4'b1101);
        chk({nm, ":latched"}, {bus.fc_index, bus.fc_write}, {e_idx, wr});
        if (wr) chk({nm, ":wdata"}, bus.fc_data_in, wdata);
        else    chk({nm, ":rdata"}, bus.fs_data_out, 16'hBEEF);
        @(negedge clk);
        idle_inputs();
        #1;
        chk({nm, ":after"}, {bus.fs_done, bus.fs_stall}, 2'b00);
        $display("txn %s addr=%h wr=%0d done", nm, addr, wr);
    endtask

    // iss0..iss3: hand-computed cycles (after accept) at which each fill read is accepted.
    task automatic miss_txn(input string nm, input logic [15:0] addr, input logic wr,
                            input logic [15:0] wdata, input logic dirty, input logic [4:0] old_tag,
                            input int iss0, input int iss1, input int iss2, input int iss3,
                            input int busy_lo, input int busy_hi, input int merr_c,
                            input int done_c, input int e_word, input logic e_err);
        int fs;
        int rj;
        int w;
        int ea;
        fs = dirty ? 6 : 2;
        @(negedge clk);
        idle_inputs();
        bus.req_addr = addr;
        bus.req_rd   = !wr;
        bus.req_wr   = wr;
        bus.req_data = wdata;
        #1;
        chk({nm, ":accept"}, {bus.fs_stall, bus.fc_comp, bus.fs_done}, 3'b110);
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            idle_inputs();
            rj = -1;
            if (c == iss0 + 2) rj = 0;
            if (c == iss1 + 2) rj = 1;
            if (c == iss2 + 2) rj = 2;
            if (c == iss3 + 2) rj = 3;
            bus.c_tag_out  = old_tag;
            bus.c_data_out = 16'hC000 | 16'(c);
            bus.c_valid    = (c == 1) || (c == done_c);
            bus.c_hit      = (c == done_c);
            bus.c_dirty    = (c == 1) && dirty;
            bus.m_busy     = (c >= busy_lo && c <= busy_hi) ? 4'b0010 : 4'b0000;
            bus.m_err      = (c == merr_c);
            bus.m_data_out = (rj >= 0) ? 16'hD0A0 + 16'(rj) : 16'h0000;
            #1;
            if (dirty && c >= 2 && c <= 5) begin
                ea = (int'(old_tag) << 11) | int'(addr & 16'h07F8) | ((c - 2) * 2);
                chk({nm, ":ev_addr"}, {bus.fm_wr, bus.fm_rd, bus.fm_addr}, {1'b1, 1'b0, 16'(ea)});
                chk({nm, ":ev_data"}, {bus.fm_data_in, bus.fc_offset, bus.fc_write},
                    {16'hC000 | 16'(c), 3'((c - 2) * 2), 1'b0});
            end
            if (c >= fs && c <= iss3) begin
                w = int'(iss0 < c) + int'(iss1 < c) + int'(iss2 < c);
                ea = int'(addr & 16'hFFF8) | (w * 2);
                chk({nm, ":rd_addr"}, {bus.fm_rd, bus.fm_wr, bus.fm_addr}, {1'b1, 1'b0, 16'(ea)});
            end
            if (rj >= 0) begin
                chk({nm, ":fill"}, {bus.fc_enable, bus.fc_write, bus.fc_comp, bus.fc_offset, bus.fc_data_in},
                    {1'b1, 1'b1, 1'b0, 3'(rj * 2), 16'hD0A0 + 16'(rj)});
            end
            if (c < done_c) begin
                chk({nm, ":busy"}, {bus.fs_done, bus.fs_stall}, 2'b01);
            end else begin
                chk({nm, ":done"}, {bus.fs_done, bus.fs_cachehit, bus.fs_err, bus.fs_stall},
                    {1'b1, 1'b0, e_err, 1'b1});
                chk({nm, ":retry"}, {bus.fc_comp, bus.fc_write, bus.fm_rd, bus.fm_wr}, {1'b1, wr, 2'b00});
                if (wr) chk({nm, ":wdata"}, bus.fc_data_in, wdata);
                else    chk({nm, ":rdata"}, bus.fs_data_out, 16'hD0A0 + 16'(e_word));
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk({nm, ":after"}, {bus.fs_done, bus.fs_stall}, 2'b00);
        $display("txn %s addr=%h wr=%0d dirty=%0d done_cycle=%0d", nm, addr, wr, dirty, done_c);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle_inputs();
        #2;
        chk("reset_out", {bus.fc_valid_in, bus.fc_enable, bus.fs_stall, bus.fs_done, bus.fm_rd, bus.fm_wr},
            6'b100000);
        chk("reset_addr", bus.fm_addr, 16'h0000);
        $display("txn reset");
        @(negedge clk);
        rst = 1'b1;

        hit_txn("rd_hit", 16'h1234, 1'b0, 16'h0000, 5'h02, 8'h46, 3'd4);

        @(negedge clk);
        idle_inputs();
        bus.req_rd = 1'b1;
        bus.req_wr = 1'b1;
        #1;
        chk("proto_err", {bus.fs_err, bus.fs_stall, bus.fc_enable, bus.fs_done}, 4'b1000);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("proto_idle", {bus.fs_err, bus.fs_stall, bus.fc_enable}, 3'b000);
        $display("txn proto_err rd&wr");

        hit_txn("wr_hit", 16'h5678, 1'b1, 16'h5A5A, 5'h0A, 8'hCF, 3'd0);
        miss_txn("rd_clean", 16'h1234, 1'b0, 16'h0000, 1'b0, 5'h00, 2, 3, 4, 5, 1, 0, -1, 8, 2, 1'b0);
        miss_txn("wr_dirty", 16'h5678, 1'b1, 16'h7E57, 1'b1, 5'h1F, 6, 7, 8, 9, 1, 0, -1, 12, 0, 1'b0);
        miss_txn("rd_merr", 16'h0102, 1'b0, 16'h0000, 1'b1, 5'h03, 6, 7, 8, 9, 1, 0, 3, 12, 1, 1'b1);
        miss_txn("rd_busy", 16'h2A16, 1'b0, 16'h0000, 1'b0, 5'h00, 2, 6, 7, 8, 3, 5, -1, 11, 3, 1'b0);

        // Reset asserted mid-fill: outputs must drop without waiting for a clock edge.
        @(negedge clk);
        idle_inputs();
        bus.req_addr = 16'h0040;
        bus.req_rd   = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus.c_valid = 1'b1;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            idle_inputs();
        end
        #1;
        chk("rst_pre", {bus.fm_rd, bus.fc_write, bus.fs_stall}, 3'b111);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async", {bus.fm_rd, bus.fc_write, bus.fc_enable, bus.fs_stall, bus.fs_done, bus.fc_valid_in},
            6'b000001);
        @(negedge clk);
        #1;
        chk("rst_held", {bus.fs_done, bus.fs_stall, bus.fm_rd}, 3'b000);
        rst = 1'b1;
        $display("txn reset_mid_fill");

        hit_txn("rd_hit2", 16'h1234, 1'b0, 16'h0000, 5'h02, 8'h46, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
